// File: rtl/tspi_pkg.sv
// Shared types and constants for the TSPI transaction sequencer.
package tspi_pkg;

    typedef enum logic [3:0] {
        SEQ_IDLE,
        SEQ_START,
        SEQ_PRE,
        SEQ_CMD,
        SEQ_WDATA,
        SEQ_TURN,
        SEQ_RDATA,
        SEQ_STAT,
        SEQ_RSP
    } tspi_seq_state_e;

    localparam logic TspiStatusOk = 1'b0;

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/tspi_txn_seq_if.sv
// Request/response handshake plus serial and port-control signals of the
// TSPI transaction sequencer; master is the sequencer side.
interface tspi_txn_seq_if #(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32
);
    logic                 req_valid_i;
    logic                 req_ready_o;
    logic                 req_write_i;
    logic [AddrWidth-1:0] req_addr_i;
    logic [DataWidth-1:0] req_wdata_i;
    logic                 rsp_valid_o;
    logic                 rsp_ready_i;
    logic [DataWidth-1:0] rsp_rdata_o;
    logic                 rsp_err_o;
    logic                 mosi_o;
    logic                 miso_i;
    logic                 new_req_o;
    logic                 en_port_ctrl_o;
    logic                 beginning_o;

    modport master (
        input  req_valid_i, req_write_i, req_addr_i, req_wdata_i,
               rsp_ready_i, miso_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
               mosi_o, new_req_o, en_port_ctrl_o, beginning_o
    );

    modport slave (
        output req_valid_i, req_write_i, req_addr_i, req_wdata_i,
               rsp_ready_i, miso_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
               mosi_o, new_req_o, en_port_ctrl_o, beginning_o
    );
endinterface

// File: rtl/tspi_shift_reg.sv
// Parallel-load register that shifts toward the MSB, taking a new bit in at
// the LSB; serves both MSB-first shift-out and LSB-in shift-in. Width >= 2.
module tspi_shift_reg #(
    parameter int unsigned Width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [Width-1:0] load_val,
    input  logic             shift_en,
    input  logic             shift_in,
    output logic [Width-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= load_val;
        end else if (shift_en) begin
            q <= {q[Width-2:0], shift_in};
        end
    end

endmodule

// File: rtl/tspi_txn_seq.sv
// TSPI transaction sequencer: serializes {write, addr} and write data on MOSI,
// captures read data and a status bit from MISO, and sequences the port ctrl.
module tspi_txn_seq
    import tspi_pkg::*;
#(
    parameter int unsigned AddrWidth  = 32,
    parameter int unsigned DataWidth  = 32,
    parameter int unsigned TurnCycles = 2
) (
    input  logic           tspi_clk_i,
    input  logic           rst_i,
    tspi_txn_seq_if.master bus
);

    localparam int unsigned HdrWidth = AddrWidth + 1;
    localparam int unsigned OutWidth = HdrWidth + DataWidth;
    localparam int unsigned CntWidth = $clog2(max3(HdrWidth, DataWidth, TurnCycles)) + 1;

    typedef logic [CntWidth-1:0] cnt_t;

    tspi_seq_state_e      state_q, state_d;
    cnt_t                 cnt_q, cnt_d;
    logic                 wr_q;
    logic                 mosi_q;
    logic                 err_q;
    logic                 accept;
    logic                 out_shift;
    logic                 rd_shift;
    logic [DataWidth-1:0] wdata_load;
    logic [OutWidth-1:0]  out_load;
    logic [OutWidth-1:0]  out_q;
    logic [DataWidth-1:0] rdata_q;
    logic                 unused_out_bits;

    assign accept     = (state_q == SEQ_IDLE) && bus.req_valid_i;
    assign wdata_load = bus.req_write_i ? bus.req_wdata_i : '0;
    assign out_load   = {bus.req_write_i, bus.req_addr_i, wdata_load};
    // mosi is registered, so the shifter advances on entry into a bit slot.
    assign out_shift  = (state_d == SEQ_CMD) || (state_d == SEQ_WDATA);
    assign rd_shift   = (state_q == SEQ_RDATA);

    // Only the MSB leaves the shifter; the rest is internal shift chain.
    assign unused_out_bits = ^out_q[OutWidth-2:0];

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            SEQ_IDLE:  if (bus.req_valid_i) state_d = SEQ_START;
            SEQ_START: state_d = SEQ_PRE;
            SEQ_PRE:   state_d = SEQ_CMD;
            SEQ_CMD:   if (cnt_q == '0) state_d = wr_q ? SEQ_WDATA : SEQ_TURN;
            SEQ_WDATA: if (cnt_q == '0) state_d = SEQ_TURN;
            SEQ_TURN:  if (cnt_q == '0) state_d = wr_q ? SEQ_STAT : SEQ_RDATA;
            SEQ_RDATA: if (cnt_q == '0) state_d = SEQ_STAT;
            SEQ_STAT:  state_d = SEQ_RSP;
            SEQ_RSP:   if (bus.rsp_ready_i) state_d = SEQ_IDLE;
            default:   state_d = SEQ_IDLE;
        endcase
    end

    always_comb begin
        cnt_d = (cnt_q != '0) ? cnt_q - cnt_t'(1) : '0;
        if (state_d != state_q) begin
            unique case (state_d)
                SEQ_CMD:              cnt_d = cnt_t'(HdrWidth - 1);
                SEQ_WDATA, SEQ_RDATA: cnt_d = cnt_t'(DataWidth - 1);
                SEQ_TURN:             cnt_d = cnt_t'(TurnCycles - 1);
                default:              cnt_d = '0;
            endcase
        end
    end

    always_ff @(posedge tspi_clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= SEQ_IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            mosi_q  <= 1'b0;
            err_q   <= TspiStatusOk;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mosi_q  <= out_shift & out_q[OutWidth-1];
            if (accept) begin
                wr_q  <= bus.req_write_i;
                err_q <= TspiStatusOk;
            end else if (state_q == SEQ_STAT) begin
                err_q <= bus.miso_i;
            end
        end
    end

    tspi_shift_reg #(.Width(OutWidth)) u_out_sr (
        .clk      (tspi_clk_i),
        .rst      (rst_i),
        .load     (accept),
        .load_val (out_load),
        .shift_en (out_shift),
        .shift_in (1'b0),
        .q        (out_q)
    );

    tspi_shift_reg #(.Width(DataWidth)) u_rd_sr (
        .clk      (tspi_clk_i),
        .rst      (rst_i),
        .load     (accept),
        .load_val ('0),
        .shift_en (rd_shift),
        .shift_in (bus.miso_i),
        .q        (rdata_q)
    );

    assign bus.req_ready_o    = (state_q == SEQ_IDLE);
    assign bus.rsp_valid_o    = (state_q == SEQ_RSP);
    assign bus.rsp_rdata_o    = rdata_q;
    assign bus.rsp_err_o      = err_q;
    assign bus.mosi_o         = mosi_q;
    assign bus.new_req_o      = (state_q == SEQ_START);
    assign bus.beginning_o    = (state_q == SEQ_PRE);
    assign bus.en_port_ctrl_o = (state_q inside {SEQ_PRE, SEQ_CMD, SEQ_WDATA,
                                                 SEQ_TURN, SEQ_RDATA, SEQ_STAT});

endmodule

// File: doc/tspi_txn_seq.md
# tspi_txn_seq

Transaction sequencer for the TSPI master port. Accepts one read or write request at a time over a valid/ready interface. Serializes a command header and write data MSB-first on `mosi_o`, and captures read data and a status bit from `miso_i`. Drives the `new_req` / `en_port_ctrl` / `beginning` controls of the TSPI port controller, which gates the TSPI clock and chip-select; it sits between the register/bus front-end and that port controller.

## Interface
Parameters:
- `AddrWidth`, 32: address bits in the command header.
- `DataWidth`, 32: read/write data bits.
- `TurnCycles`, 2: bus turnaround cycles before slave-driven bits; must be ≥ 1.

Ports:
- `tspi_clk_i`  in  1  sole clock; the TSPI bit clock, with all logic on its rising edge.
- `rst_i`  in  1  asynchronous, active-high reset.
- `req_valid_i`  in  1  request valid.
- `req_ready_o`  out  1  request accepted when high together with `req_valid_i`.
- `req_write_i`  in  1  1 = write, 0 = read.
- `req_addr_i`  in  AddrWidth  target address.
- `req_wdata_i`  in  DataWidth  write data; ignored for reads.
- `rsp_valid_o`  out  1  response valid.
- `rsp_ready_i`  in  1  response consumed.
- `rsp_rdata_o`  out  DataWidth  read data; 0 for writes.
- `rsp_err_o`  out  1  status bit from the slave (1 = error).
- `mosi_o`  out  1  serial data to the slave.
- `miso_i`  in  1  serial data from the slave.
- `new_req_o`  out  1  to port ctrl; forces the clock and CS idle-high.
- `en_port_ctrl_o`  out  1  to port ctrl; enables the clock.
- `beginning_o`  out  1  to port ctrl; keeps CS high while the clock runs (preamble).

## Operation
- FSM states: IDLE → START → PRE → CMD → (write: WDATA → TURN) / (read: TURN → RDATA) → STAT → RSP → IDLE.
- **IDLE**:
  - `req_ready_o` = 1.
  - On handshake, latch write, addr and wdata into the shift register and the header; clear `rsp_rdata_o` and `rsp_err_o`.
- **START**: 1 cycle, `new_req_o` = 1.
- **PRE**: 1 cycle, `en_port_ctrl_o` = 1, `beginning_o` = 1.
- **CMD**:
  - AddrWidth+1 cycles; `mosi_o` carries {write, addr}, MSB first.
  - `en_port_ctrl_o` = 1 in CMD and every following state through STAT; `beginning_o` = 0.
- **WDATA**: DataWidth cycles; `mosi_o` carries wdata, MSB first.
- **TURN**: TurnCycles cycles; `mosi_o` = 0.
  - After WDATA, TURN goes to STAT.
  - After CMD on a read, TURN goes to RDATA.
- **RDATA**: DataWidth cycles; `miso_i` is shifted into `rsp_rdata_o` LSB-in on each rising edge, so the first bit ends up as the MSB.
- **STAT**: 1 cycle; `miso_i` is registered into `rsp_err_o`.
- **RSP**:
  - `en_port_ctrl_o` = 0 and `rsp_valid_o` = 1; hold until `rsp_ready_i`, then go to IDLE.
  - `rsp_rdata_o` and `rsp_err_o` are stable while valid.
- Bit counter: width `$clog2(max(AddrWidth+1, DataWidth, TurnCycles))+1`. Loaded with length−1 on state entry; the state exits when the counter reaches 0.
- `mosi_o` is registered and is 0 outside CMD/WDATA.
- Port control outputs are decoded from the state register only; no input-to-output combinational paths exist except none.

## Timing
- Reset values:
  - state = IDLE; `req_ready_o` = 1.
  - `rsp_valid_o`, `rsp_rdata_o`, `rsp_err_o`, `mosi_o`, `new_req_o`, `en_port_ctrl_o` and `beginning_o` are all 0.
- Accept cycle = cycle 0, then START = 1 and PRE = 2.
- CMD covers 3 .. 3+AddrWidth.
- Latency from accept to `rsp_valid_o`: 4+AddrWidth+DataWidth+TurnCycles+1 cycles, identical for read and write. This is 71 cycles with the defaults.
- With defaults:
  - Write: CMD 3–35, WDATA 36–67, TURN 68–69, STAT 70, RSP from 71.
  - Read: CMD 3–35, TURN 36–37, RDATA 38–69, STAT 70, RSP from 71.
- Back-to-back transactions: a response handshake in cycle n puts the FSM in IDLE at n+1. The earliest next accept is n+1, so there is no overlap.
- `req_valid_i` while busy is ignored (`req_ready_o` = 0). The request fields may change freely after the accept.
- Reset asserted mid-transaction:
  - The FSM returns to IDLE immediately (asynchronously) and the partial response is discarded.
  - `en_port_ctrl_o` = 0 and `new_req_o` = 0, so the port idles high.

## Structure
- `tspi_pkg` gains:
  - `tspi_seq_state_e`, the FSM enum.
  - `TspiStatusOk` = 1'b0.
- One optional sub-module, `tspi_shift_reg`: a parallel-load MSB-first shift-out and LSB-in shift-in register, parameterized by width.
- `tspi_port_ctrl` is instantiated by the parent, not inside this block.

## Test plan
- Write, addr=0x0000_1234, wdata=0xDEAD_BEEF, `miso_i` = 0 in STAT:
  - `mosi_o` carries 1, 0x00001234, 0xDEADBEEF over cycles 3–67.
  - Response at cycle 71 with err=0, rdata=0.
- Read, addr=0x8000_0000; slave drives 0xA5A5_5A5A in RDATA and 1 in STAT:
  - `rsp_rdata_o` = 0xA5A55A5A, `rsp_err_o` = 1, valid at cycle 71.
- Check the port-control sequence on any transaction:
  - `new_req_o` is high only in cycle 1 and `beginning_o` only in cycle 2.
  - `en_port_ctrl_o` is high in cycles 2–70.
- Hold `rsp_ready_i` = 0 for 10 cycles after a read:
  - `rsp_valid_o` and the data are stable and `en_port_ctrl_o` = 0.
  - A second `req_valid_i` is not accepted until the cycle after the handshake.
- Assert `rst_i` at cycle 40 of a write:
  - All outputs go to their reset values without waiting for a clock edge.
  - A new read after release completes normally.
